// File: rtl/tcam_search_pipe_pkg.sv
// rtl/tcam_search_pipe_pkg.sv - shared defaults, mask polarity and index-width helper for the TCAM search pipe
package tcam_search_pipe_pkg;

  localparam int CAM_WIDTH_DEF = 8;
  localparam int CAM_DEPTH_DEF = 8;

  // A mask bit equal to this value means "ignore this bit" in both stored and search masks
  localparam logic MASK_IGNORE = 1'b1;

  // Smallest r with 2**r >= value; a depth of 1 still gets a 1-bit index
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tcam_search_pipe_prio_enc.sv
// rtl/tcam_search_pipe_prio_enc.sv - combinational match-vector to lowest-index/hit/multi encoder
module cam_priority_encoder
  import tcam_search_pipe_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH_DEF,
  parameter int ADDR_W = clog2(CAM_DEPTH_DEF)
) (
  input  logic [DEPTH-1:0]  vec_i,
  output logic [ADDR_W-1:0] index_o,
  output logic              hit_o,
  output logic              multi_o
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) index_o = ADDR_W'(i);
    end
    hit_o   = |vec_i;
    multi_o = |(vec_i & (vec_i - DEPTH'(1)));
  end

endmodule

// File: rtl/tcam_search_pipe.sv
// rtl/tcam_search_pipe.sv - ternary CAM with a two-stage valid/ready search pipeline
module tcam_search_pipe
  import tcam_search_pipe_pkg::*;
#(
  parameter int CAM_WIDTH = CAM_WIDTH_DEF,
  parameter int CAM_DEPTH = CAM_DEPTH_DEF,
  localparam int ADDR_W   = clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CAM_WIDTH-1:0] wr_data,
  input  logic [CAM_WIDTH-1:0] wr_mask,
  input  logic                 wr_valid,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CAM_WIDTH-1:0] req_key,
  input  logic [CAM_WIDTH-1:0] req_mask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CAM_DEPTH-1:0] resp_vector,
  output logic                 resp_hit,
  output logic                 resp_multi,
  output logic [ADDR_W-1:0]    resp_index
);

  logic [CAM_WIDTH-1:0] data_q [CAM_DEPTH];
  logic [CAM_WIDTH-1:0] mask_q [CAM_DEPTH];
  logic [CAM_DEPTH-1:0] valid_q;

  logic                 s1_full_q;
  logic [CAM_DEPTH-1:0] s1_vec_q;

  logic                 s2_full_q;
  logic [CAM_DEPTH-1:0] s2_vec_q;
  logic                 s2_hit_q;
  logic                 s2_multi_q;
  logic [ADDR_W-1:0]    s2_index_q;

  logic                 wr_in_range;
  logic [CAM_WIDTH-1:0] req_care;
  logic [CAM_DEPTH-1:0] match_vec;
  logic                 accept;
  logic                 s2_take;
  logic                 s1_to_s2;
  logic [ADDR_W-1:0]    enc_index;
  logic                 enc_hit;
  logic                 enc_multi;

  // Addresses past the last entry (non power-of-two depth) are silently dropped
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(CAM_DEPTH));

  // S2 can take new data when empty or when its current result is leaving this cycle
  assign s2_take  = ~s2_full_q | resp_ready;
  assign s1_to_s2 = s1_full_q & s2_take;

  // Held low during reset and flush; otherwise only a completely blocked pipe stalls requests
  assign req_ready = rst & ~flush & ~(s1_full_q & s2_full_q & ~resp_ready);
  assign accept    = req_valid & req_ready;

  assign req_care = {CAM_WIDTH{MASK_IGNORE}} ^ req_mask;

  // Ternary compare of the key against the array as it stands before this cycle's write
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      match_vec[i] = valid_q[i] &
                     ~|((data_q[i] ^ req_key) & ({CAM_WIDTH{MASK_IGNORE}} ^ mask_q[i]) & req_care);
    end
  end

  // Entry payload is not reset; a write during flush still lands its data and mask
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      data_q[wr_addr] <= wr_data;
      mask_q[wr_addr] <= wr_mask;
    end
  end

  // Valid bits: flush overrides any same-cycle write or invalidate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en && wr_in_range) begin
      valid_q[wr_addr] <= wr_valid;
    end
  end

  // S1: capture the match vector of an accepted search
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_full_q <= 1'b0;
      s1_vec_q  <= '0;
    end else if (accept) begin
      s1_full_q <= 1'b1;
      s1_vec_q  <= match_vec;
    end else if (s1_to_s2) begin
      s1_full_q <= 1'b0;
    end
  end

  cam_priority_encoder #(
    .DEPTH  (CAM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec_i   (s1_vec_q),
    .index_o (enc_index),
    .hit_o   (enc_hit),
    .multi_o (enc_multi)
  );

  // S2: register the encoded response; a stalled result is held untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_full_q  <= 1'b0;
      s2_vec_q   <= '0;
      s2_hit_q   <= 1'b0;
      s2_multi_q <= 1'b0;
      s2_index_q <= '0;
    end else if (s2_take) begin
      s2_full_q <= s1_full_q;
      if (s1_full_q) begin
        s2_vec_q   <= s1_vec_q;
        s2_hit_q   <= enc_hit;
        s2_multi_q <= enc_multi;
        s2_index_q <= enc_index;
      end
    end
  end

  assign resp_valid  = s2_full_q;
  assign resp_vector = s2_vec_q;
  assign resp_hit    = s2_hit_q;
  assign resp_multi  = s2_multi_q;
  assign resp_index  = s2_index_q;

endmodule
